// File: rtl/lane_sequencer_if.sv
// Operand/result handshake bundle for lane_sequencer.
// master = producer/consumer side, slave = sequencer side.
interface lane_sequencer_if #(
    parameter int LANES   = 4,
    parameter int A_WIDTH = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*A_WIDTH-1:0]   in_a;
    logic [2*LANES-1:0]         in_b;
    logic [2*LANES-1:0]         in_c;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES-1:0]           out_d;
    logic [LANES-1:0]           out_e;
    logic                       busy;

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_d, out_e, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_d, out_e, busy
    );
endinterface

// File: rtl/lane_sequencer.sv
// One shared lane cell evaluated once per cycle over LANES captured operand
// slices; IDLE -> RUN (LANES cycles) -> DONE with valid/ready on both sides.
module lane_sequencer_cell (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] c,
    output logic       d,
    output logic       e
);
    assign d = ((a[0] | b[0]) & (a[1] | b[1])) | c[1];
    assign e = ((a[1] | b[0]) & (a[0] | b[1])) | c[0];
endmodule

module lane_sequencer #(
    parameter int LANES   = 4,
    parameter int A_WIDTH = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    lane_sequencer_if.slave   bus
);
    localparam int CW = (LANES > 2) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [LANES-1:0][1:0]   a_q;
    logic [LANES-1:0][1:0]   b_q;
    logic [LANES-1:0][1:0]   c_q;
    logic [LANES-1:0]        d_q;
    logic [LANES-1:0]        e_q;
    logic                    lane_d;
    logic                    lane_e;

    lane_sequencer_cell u_lane (
        .a (a_q[cnt]),
        .b (b_q[cnt]),
        .c (c_q[cnt]),
        .d (lane_d),
        .e (lane_e)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            e_q   <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    // only bits [1:0] of each a slice feed the lane function
                    for (int i = 0; i < LANES; i++)
                        a_q[i] <= bus.in_a[i*A_WIDTH +: 2];
                    b_q   <= bus.in_b;
                    c_q   <= bus.in_c;
                    d_q   <= '0;
                    e_q   <= '0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    d_q[cnt] <= lane_d;
                    e_q[cnt] <= lane_e;
                    if (cnt == LAST) state <= DONE;
                    else             cnt   <= cnt + 1'b1;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.out_d     = d_q;
    assign bus.out_e     = e_q;
endmodule
